// File: rtl/riscv_data_mem_resp.sv
// Data memory with zero-latency loads, byte-lane stores, a zero-fill INIT sweep after reset,
// error detection and capture of the first error address, and serviced load/store counters.
module riscv_data_mem_resp #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_mem_req_i,
   input  logic [31:0] data_mem_addr_i,
   input  logic [1:0]  data_mem_byte_en_i,
   input  logic        data_mem_wr_i,
   input  logic [31:0] data_mem_wr_data_i,
   output logic [31:0] data_mem_rd_data_o,
   output logic        mem_ready_o,
   output logic        data_mem_err_o,
   output logic        err_sticky_o,
   output logic [31:0] err_addr_o,
   output logic [15:0] rd_count_o,
   output logic [15:0] wr_count_o
);

   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic {INIT, READY} state_t;

   state_t        state;
   logic [IW-1:0] init_idx;
   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   word_idx;
   logic [IW-1:0] idx;
   logic          out_of_range;
   logic          misaligned;
   logic          serviced;
   logic [31:0]   rd_word;
   logic [31:0]   rd_sel;

   assign word_idx     = (data_mem_addr_i - BASE_ADDR) >> 2;
   assign idx          = word_idx[IW-1:0];
   assign out_of_range = (data_mem_addr_i < BASE_ADDR) || (word_idx >= 32'(DEPTH_WORDS));
   assign misaligned   = ((data_mem_byte_en_i == 2'b01) && data_mem_addr_i[0]) ||
                         ((data_mem_byte_en_i == 2'b11) && (data_mem_addr_i[1:0] != 2'b00));

   // Reset gates readiness immediately so nothing is serviced on a reset edge.
   assign mem_ready_o    = (state == READY) && !reset;
   assign data_mem_err_o = data_mem_req_i && (!mem_ready_o || out_of_range || misaligned ||
                                              (data_mem_byte_en_i == 2'b10));
   assign serviced       = data_mem_req_i && !data_mem_err_o;

   assign rd_word = mem[idx];

   always_comb begin
      rd_sel = 32'h0;
      case (data_mem_byte_en_i)
         2'b00:   rd_sel = {24'h0, rd_word[8*data_mem_addr_i[1:0] +: 8]};
         2'b01:   rd_sel = {16'h0, rd_word[16*data_mem_addr_i[1] +: 16]};
         2'b11:   rd_sel = rd_word;
         default: rd_sel = 32'h0;
      endcase
   end

   assign data_mem_rd_data_o = serviced ? rd_sel : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= INIT;
         init_idx     <= '0;
         err_sticky_o <= 1'b0;
         err_addr_o   <= 32'h0;
         rd_count_o   <= 16'h0;
         wr_count_o   <= 16'h0;
      end else begin
         if (state == INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == IW'(DEPTH_WORDS - 1)) state <= READY;
         end
         if (serviced && data_mem_wr_i)  wr_count_o <= wr_count_o + 16'h1;
         if (serviced && !data_mem_wr_i) rd_count_o <= rd_count_o + 16'h1;
         if (data_mem_err_o && !err_sticky_o) begin
            err_sticky_o <= 1'b1;
            err_addr_o   <= data_mem_addr_i;
         end
      end
   end

   // Storage has no reset; the INIT sweep clears it one word per cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == INIT) begin
            mem[init_idx] <= 32'h0;
         end else if (serviced && data_mem_wr_i) begin
            case (data_mem_byte_en_i)
               2'b00:   mem[idx][8*data_mem_addr_i[1:0] +: 8] <= data_mem_wr_data_i[7:0];
               2'b01:   mem[idx][16*data_mem_addr_i[1] +: 16] <= data_mem_wr_data_i[15:0];
               default: mem[idx] <= data_mem_wr_data_i;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_riscv_data_mem_resp.sv
// Directed bench for riscv_data_mem_resp with DEPTH_WORDS=16.
module tb_riscv_data_mem_resp;

   localparam logic [31:0] BASE = 32'h0000_2000;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [31:0] addr;
   logic [1:0]  be;
   logic        wr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        sticky;
   logic [31:0] err_addr;
   logic [15:0] rd_count;
   logic [15:0] wr_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_data_mem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .data_mem_req_i(req), .data_mem_addr_i(addr), .data_mem_byte_en_i(be),
      .data_mem_wr_i(wr), .data_mem_wr_data_i(wdata),
      .data_mem_rd_data_o(rdata), .mem_ready_o(ready), .data_mem_err_o(err),
      .err_sticky_o(sticky), .err_addr_o(err_addr),
      .rd_count_o(rd_count), .wr_count_o(wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [31:0] a, input logic [1:0] b,
                        input logic w, input logic [31:0] d);
      req = r; addr = a; be = b; wr = w; wdata = d;
      #1;
   endtask

   task automatic wait_init();
      for (int i = 0; i < 15; i++) step();
      chk("ready_low_15", 32'(ready), 32'h0);
      step();
      chk("ready_high_16", 32'(ready), 32'h1);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b1, BASE, 2'b11, 1'b0, 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_err", 32'(err), 32'h1);
      chk("rst_rdata", rdata, 32'h0);
      step();
      step();
      chk("rst_rd_count", 32'(rd_count), 32'h0);
      chk("rst_sticky", 32'(sticky), 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);
      reset = 1'b0;
      drive(1'b0, BASE, 2'b11, 1'b0, 32'h0);
      wait_init();

      // first transactions
      drive(1'b1, BASE + 60, 2'b11, 1'b0, 32'h0);
      chk("ld_last_err", 32'(err), 32'h0);
      chk("ld_last_zero", rdata, 32'h0);
      step();
      chk("rd_count_1", 32'(rd_count), 32'h1);
      drive(1'b1, BASE + 4, 2'b11, 1'b1, 32'hDEAD_BEEF);
      step();
      drive(1'b1, BASE + 6, 2'b00, 1'b1, 32'hAAAA_AA55);
      step();
      chk("wr_count_2", 32'(wr_count), 32'h2);
      drive(1'b1, BASE + 4, 2'b11, 1'b0, 32'h0);
      chk("ld_word_merge", rdata, 32'hDE55_BEEF);
      step();
      drive(1'b1, BASE + 6, 2'b01, 1'b0, 32'h0);
      chk("ld_half_hi", rdata, 32'h0000_DE55);
      step();
      drive(1'b1, BASE + 7, 2'b00, 1'b0, 32'h0);
      chk("ld_byte3", rdata, 32'h0000_00DE);
      step();
      drive(1'b1, BASE + 5, 2'b00, 1'b0, 32'h0);
      chk("ld_byte1", rdata, 32'h0000_00BE);
      step();
      chk("rd_count_5", 32'(rd_count), 32'h5);

      // misaligned half store
      drive(1'b1, BASE + 1, 2'b01, 1'b1, 32'h0000_1234);
      chk("mis_err", 32'(err), 32'h1);
      chk("mis_rdata", rdata, 32'h0);
      step();
      chk("mis_sticky", 32'(sticky), 32'h1);
      chk("mis_err_addr", err_addr, BASE + 1);
      chk("mis_wr_count", 32'(wr_count), 32'h2);
      drive(1'b1, BASE + 4, 2'b11, 1'b0, 32'h0);
      chk("mis_unchanged", rdata, 32'hDE55_BEEF);
      step();
      drive(1'b1, BASE + 3, 2'b10, 1'b0, 32'h0);
      chk("rsv_err", 32'(err), 32'h1);
      chk("rsv_rdata", rdata, 32'h0);
      step();
      chk("second_err_addr", err_addr, BASE + 1);
      drive(1'b1, BASE + 64, 2'b11, 1'b0, 32'h0);
      chk("oor_err", 32'(err), 32'h1);
      chk("oor_rdata", rdata, 32'h0);
      step();
      drive(1'b1, BASE - 4, 2'b11, 1'b0, 32'h0);
      chk("below_err", 32'(err), 32'h1);
      step();
      chk("err_rd_count", 32'(rd_count), 32'h6);
      chk("err_wr_count", 32'(wr_count), 32'h2);
      drive(1'b0, BASE + 4, 2'b11, 1'b0, 32'h0);
      chk("idle_rdata", rdata, 32'h0);
      chk("idle_err", 32'(err), 32'h0);

      // reset in READY with a store in flight, then again mid-INIT
      reset = 1'b1;
      drive(1'b1, BASE + 8, 2'b11, 1'b1, 32'h1111_2222);
      chk("rrst_ready", 32'(ready), 32'h0);
      chk("rrst_err", 32'(err), 32'h1);
      step();
      reset = 1'b0;
      drive(1'b0, BASE, 2'b11, 1'b0, 32'h0);
      chk("rrst_rd_count", 32'(rd_count), 32'h0);
      chk("rrst_wr_count", 32'(wr_count), 32'h0);
      chk("rrst_sticky", 32'(sticky), 32'h0);
      chk("rrst_err_addr", err_addr, 32'h0);
      for (int i = 0; i < 5; i++) step();
      drive(1'b1, BASE + 12, 2'b11, 1'b0, 32'h0);
      chk("init_req_err", 32'(err), 32'h1);
      chk("init_req_rdata", rdata, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      drive(1'b0, BASE, 2'b11, 1'b0, 32'h0);
      wait_init();
      drive(1'b1, BASE + 4, 2'b11, 1'b0, 32'h0);
      chk("post_rst_w1", rdata, 32'h0);
      step();
      drive(1'b1, BASE + 8, 2'b11, 1'b0, 32'h0);
      chk("post_rst_w2", rdata, 32'h0);
      step();

      // counter wrap: two loads done, one store, then 65534 more loads
      drive(1'b1, BASE + 16, 2'b11, 1'b1, 32'h0BAD_F00D);
      step();
      drive(1'b1, BASE + 16, 2'b11, 1'b0, 32'h0);
      chk("wrap_data", rdata, 32'h0BAD_F00D);
      for (int i = 0; i < 65533; i++) step();
      chk("rd_count_ffff", 32'(rd_count), 32'h0000_FFFF);
      step();
      chk("rd_count_wrap", 32'(rd_count), 32'h0);
      chk("wrap_wr_count", 32'(wr_count), 32'h1);
      drive(1'b0, BASE, 2'b11, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
